// File: rtl/gradient_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gradient_sequencer : frame-synchronised pattern scheduler and CPU pass-through for the gradient core slot bus
// Rev 1.0
// ---------------------------------------------------------------------------
module gradient_sequencer #(
  parameter int DEPTH = 16,
  parameter int PW    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] x_i,
  input  logic [10:0] y_i,
  input  logic        cs_i,
  input  logic        write_i,
  input  logic [13:0] addr_i,
  input  logic [31:0] wr_data_i,
  output logic        vc_cs_o,
  output logic        vc_write_o,
  output logic [13:0] vc_addr_o,
  output logic [31:0] vc_wr_data_o,
  output logic        busy_o,
  output logic [3:0]  idx_o,
  output logic        pend_ovf_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_W_BYP  = 3'd1;
  localparam logic [2:0] c_W_RGB  = 3'd2;
  localparam logic [2:0] c_W_SIZE = 3'd3;
  localparam logic [2:0] c_PASS   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          enable_q;
  logic [PW-1:0] period_q, fcnt_q;
  logic [3:0]    length_q, idx_q;
  logic          sof_d_q, step_pend_q;
  logic [5:0]    snap_q;
  logic          pend_valid_q, pend_ovf_q;
  logic [1:0]    pend_addr_q;
  logic [31:0]   pend_data_q;
  logic          vc_cs_q;
  logic [13:0]   vc_addr_q;
  logic [31:0]   vc_data_q;
  logic [5:0]    tbl_q [DEPTH];

  logic          w_wr, w_ctrl_wr, w_per_wr, w_len_wr, w_clr_ovf, w_pass_wr, w_tbl_wr;
  logic [4:0]    w_a;
  logic          w_origin, w_sof, w_step, w_take_step, w_pend_full, w_capture;
  logic [PW-1:0] w_pm1;
  logic [3:0]    w_lm1, w_idx_adv;
  logic          w_unused;

  assign w_wr      = cs_i & write_i;
  assign w_a       = addr_i[4:0];
  assign w_ctrl_wr = w_wr && (w_a == 5'h00);
  assign w_per_wr  = w_wr && (w_a == 5'h01);
  assign w_len_wr  = w_wr && (w_a == 5'h02);
  assign w_clr_ovf = w_wr && (w_a == 5'h03);
  assign w_pass_wr = w_wr && ((w_a == 5'h08) || (w_a == 5'h09) || (w_a == 5'h0A));
  assign w_tbl_wr  = w_wr && w_a[4] && ({1'b0, w_a[3:0]} < 5'(DEPTH));

  // A held origin (slow pixel clock) yields only one start-of-frame pulse.
  assign w_origin    = (x_i == 11'd0) && (y_i == 11'd0);
  assign w_sof       = w_origin && !sof_d_q;
  assign w_pm1       = (period_q == '0) ? '0 : period_q - 1'b1;
  assign w_step      = w_sof && enable_q && (fcnt_q == w_pm1);
  assign w_take_step = w_step || step_pend_q;

  assign w_lm1     = (length_q == 4'd0) ? 4'd0 : length_q - 4'd1;
  assign w_idx_adv = (idx_q >= w_lm1) ? 4'd0 : idx_q + 4'd1;

  // The slot being drained this cycle counts as free for a new capture.
  assign w_pend_full = pend_valid_q && (state_q != c_PASS);
  assign w_capture   = w_pass_wr && !w_pend_full;

  assign w_unused = ^{addr_i[13:5], wr_data_i};

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (w_take_step)       state_d = c_W_BYP;
        else if (pend_valid_q) state_d = c_PASS;
      end
      c_W_BYP:  state_d = c_W_RGB;
      c_W_RGB:  state_d = c_W_SIZE;
      c_W_SIZE: state_d = pend_valid_q ? c_PASS : c_IDLE;
      c_PASS:   state_d = c_IDLE;
      default:  state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_tbl_wr) tbl_q[w_a[IW-1:0]] <= wr_data_i[5:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= c_IDLE;
      enable_q     <= 1'b0;
      period_q     <= '0;
      length_q     <= 4'd0;
      fcnt_q       <= '0;
      idx_q        <= 4'd0;
      sof_d_q      <= 1'b0;
      step_pend_q  <= 1'b0;
      snap_q       <= 6'd0;
      pend_valid_q <= 1'b0;
      pend_ovf_q   <= 1'b0;
      pend_addr_q  <= 2'd0;
      pend_data_q  <= 32'd0;
      vc_cs_q      <= 1'b0;
      vc_addr_q    <= 14'd0;
      vc_data_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      sof_d_q <= w_origin;
      if (w_per_wr) period_q <= wr_data_i[PW-1:0];
      if (w_len_wr) length_q <= wr_data_i[3:0];
      if (enable_q && w_sof) fcnt_q <= w_step ? '0 : fcnt_q + 1'b1;
      if (state_q == c_W_SIZE) idx_q <= enable_q ? w_idx_adv : 4'd0;

      if ((state_q == c_IDLE) && w_take_step) begin
        step_pend_q <= 1'b0;
        snap_q      <= tbl_q[idx_q[IW-1:0]];
      end else if (w_step) begin
        step_pend_q <= 1'b1;
      end

      if (w_ctrl_wr) begin
        enable_q <= wr_data_i[0];
        if (!wr_data_i[0]) begin
          fcnt_q      <= '0;
          idx_q       <= 4'd0;
          step_pend_q <= 1'b0;
        end
      end

      if (w_capture) begin
        pend_valid_q <= 1'b1;
        pend_addr_q  <= w_a[1:0];
        pend_data_q  <= wr_data_i;
      end else if (state_q == c_PASS) begin
        pend_valid_q <= 1'b0;
      end

      if (w_clr_ovf) pend_ovf_q <= 1'b0;
      if (w_pass_wr && w_pend_full) pend_ovf_q <= 1'b1;

      vc_cs_q <= (state_q != c_IDLE);
      case (state_q)
        c_W_BYP:  begin vc_addr_q <= 14'd0; vc_data_q <= {31'd0, snap_q[0]};   end
        c_W_RGB:  begin vc_addr_q <= 14'd1; vc_data_q <= {29'd0, snap_q[3:1]}; end
        c_W_SIZE: begin vc_addr_q <= 14'd2; vc_data_q <= {30'd0, snap_q[5:4]}; end
        c_PASS:   begin vc_addr_q <= {12'd0, pend_addr_q}; vc_data_q <= pend_data_q; end
        default:  begin vc_addr_q <= 14'd0; vc_data_q <= 32'd0; end
      endcase
    end
  end

  assign vc_cs_o      = vc_cs_q;
  assign vc_write_o   = vc_cs_q;
  assign vc_addr_o    = vc_addr_q;
  assign vc_wr_data_o = vc_data_q;
  assign busy_o       = (state_q != c_IDLE);
  assign idx_o        = idx_q;
  assign pend_ovf_o   = pend_ovf_q;

endmodule
`default_nettype wire
